// File: rtl/round_check_pkg.sv
// Shared game definitions for the round checker: controller states,
// button encoding, round-length limits and small step helpers.
package round_check_pkg;

  // Highest round_len value a player can reach; a correct round here wins.
  localparam int MAX_ROUND_DEF = 15;

  // Width of round lengths / step indices and of a button symbol.
  localparam int LEN_W = 4;
  localparam int BTN_W = 2;

  typedef logic [LEN_W-1:0] len_t;
  typedef logic [BTN_W-1:0] btn_code_t;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_WIN  = 2'd2
  } state_t;

  // 2-bit button encoding shared with the pattern source and the panel.
  typedef enum logic [BTN_W-1:0] {
    BTN_RED    = 2'd0,
    BTN_GREEN  = 2'd1,
    BTN_BLUE   = 2'd2,
    BTN_YELLOW = 2'd3
  } btn_t;

  // The step under check is the final one of the round. Using >= keeps
  // exp_idx from ever running past round_len, even if round_len is
  // disturbed while a round is in progress.
  function automatic logic is_last_step(input len_t idx, input len_t len);
    return (idx >= len);
  endfunction

  // A press matches when it carries the symbol expected for this step.
  function automatic logic is_match(input btn_code_t pressed, input btn_code_t expected);
    return (pressed == expected);
  endfunction

endpackage

// File: rtl/round_check_timer.sv
// Inactivity timer for the round checker. Counts idle cycles while enabled,
// flags expiry once TIMEOUT-1 idle cycles have already elapsed, and holds at
// that terminal count rather than wrapping.
module round_timer #(
  parameter int TIMEOUT = 1000,
  parameter int TW      = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TW-1:0] TC = TW'(TIMEOUT - 1);

  logic [TW-1:0] r_cnt;
  logic          w_at_tc;

  assign w_at_tc = (r_cnt == TC);
  assign expired = w_at_tc;

  // Idle counter: clear wins over count, saturate at terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en && !w_at_tc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/round_check.sv
// Round checker for a memory game: compares player presses against the
// expected pattern, requests the next round length from the external
// sequence memory, and reports wrong presses, timeouts and wins.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | no round open; waits for start, presses are ignored
//   ST_WAIT | input phase; checks presses, idle timer running
//   ST_WIN  | final round completed; holds win until start
module round_check
  import round_check_pkg::*;
#(
  parameter int MAX_ROUND = MAX_ROUND_DEF,
  parameter int TIMEOUT   = 1000,
  parameter int TW        = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] round_len,
  input  logic             btn_valid,
  input  logic [BTN_W-1:0] btn_id,
  input  logic [BTN_W-1:0] exp_id,
  output logic [LEN_W-1:0] exp_idx,
  output logic             load,
  output logic [LEN_W-1:0] next_len,
  output logic             busy,
  output logic             fail,
  output logic             win
);

  localparam len_t MAX_LEN = len_t'(MAX_ROUND);

  state_t r_state;
  state_t w_state_nxt;

  len_t r_exp_idx;
  logic r_load;
  len_t r_next_len;
  logic r_fail;

  len_t w_exp_idx_d;
  logic w_load_d;
  len_t w_next_len_d;
  logic w_fail_d;

  logic w_in_wait;
  logic w_hit;
  logic w_miss;
  logic w_last;
  logic w_at_max;
  logic w_tmo;
  logic w_tmr_clr;
  logic w_tmr_en;
  logic w_expired;

  // Press classification for the step under check.
  assign w_in_wait = (r_state == ST_WAIT);
  assign w_hit     = w_in_wait && btn_valid && is_match(btn_id, exp_id);
  assign w_miss    = w_in_wait && btn_valid && !is_match(btn_id, exp_id);
  assign w_last    = is_last_step(r_exp_idx, round_len);
  assign w_at_max  = (round_len >= MAX_LEN);
  // A press in the expiry cycle is handled as a press, never as a timeout.
  assign w_tmo     = w_in_wait && !btn_valid && w_expired;

  // The timer idles at zero outside the input phase, so every round starts
  // from a fresh count; each correct intermediate press restarts it.
  assign w_tmr_clr = !w_in_wait || (w_hit && !w_last);
  assign w_tmr_en  = w_in_wait && !btn_valid;

  round_timer #(
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (w_tmr_clr),
    .en      (w_tmr_en),
    .expired (w_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_hit && w_last) begin
          w_state_nxt = w_at_max ? ST_WIN : ST_IDLE;
        end else if (w_miss || w_tmo) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WIN: begin
        if (start) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs; pulses default back to zero.
  always_comb begin
    w_exp_idx_d  = r_exp_idx;
    w_load_d     = 1'b0;
    w_next_len_d = '0;
    w_fail_d     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_exp_idx_d = '0;
        end
      end
      ST_WAIT: begin
        if (w_hit && !w_last) begin
          w_exp_idx_d = r_exp_idx + 1'b1;
        end else if (w_hit && w_last) begin
          w_exp_idx_d = '0;
          if (!w_at_max) begin
            w_load_d     = 1'b1;
            w_next_len_d = round_len + 1'b1;
          end
        end else if (w_miss || w_tmo) begin
          // Restart the game from the shortest round.
          w_exp_idx_d  = '0;
          w_load_d     = 1'b1;
          w_next_len_d = '0;
          w_fail_d     = 1'b1;
        end
      end
      ST_WIN: begin
        if (start) begin
          w_load_d     = 1'b1;
          w_next_len_d = '0;
        end
      end
      default: begin
        w_exp_idx_d = '0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exp_idx  <= '0;
      r_load     <= 1'b0;
      r_next_len <= '0;
      r_fail     <= 1'b0;
    end else begin
      r_exp_idx  <= w_exp_idx_d;
      r_load     <= w_load_d;
      r_next_len <= w_next_len_d;
      r_fail     <= w_fail_d;
    end
  end

  assign exp_idx  = r_exp_idx;
  assign load     = r_load;
  assign next_len = r_next_len;
  assign fail     = r_fail;
  assign busy     = (r_state == ST_WAIT);
  assign win      = (r_state == ST_WIN);

endmodule
